// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder
// Card-side engine for the SD CMD line. It receives 48-bit host command
// tokens, checks framing and CRC7, and presents index/argument to the card
// logic. It then serialises the 48-bit (R1/R3/R6/R7) or 136-bit (R2)
// response handed back by the card logic.
//
// Configuration macro:
//   SD_CMD_CRC_CHECK_EN - when defined, the received command CRC7 is checked
//                         and ocrc_err can pulse. When undefined, the
//                         received CRC bits are ignored and ocrc_err stays 0.
//                         Response CRC7 generation is always present.
//
// Ports:
//   iclk, irst_n        SD clock (rising edge), async active-low reset
//   icmd_sd             CMD line input
//   ocmd_sd/ocmd_sd_en  CMD line output data / output enable
//   ocmd_valid          pulse: good command received
//   ocmd_index/ocmd_arg fields of the last good command
//   ocrc_err/oframe_err pulse: CRC7 mismatch / bad transmission or end bit
//   oresp_ready         high while waiting for a response request
//   iresp_valid         response request (accepted with oresp_ready)
//   iresp_long          1 = R2 (136-bit), 0 = 48-bit response
//   iresp_index/arg     fields of a 48-bit response
//   iresp_cidcsd        CID/CSD bits [127:8] for R2
//   oresp_done          pulse after the response end bit has been driven
module sd_cmd_responder #(
  parameter int NCR          = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         icmd_sd,
  output logic         ocmd_sd,
  output logic         ocmd_sd_en,
  output logic         ocmd_valid,
  output logic [5:0]   ocmd_index,
  output logic [31:0]  ocmd_arg,
  output logic         ocrc_err,
  output logic         oframe_err,
  output logic         oresp_ready,
  input  logic         iresp_valid,
  input  logic         iresp_long,
  input  logic [5:0]   iresp_index,
  input  logic [31:0]  iresp_arg,
  input  logic [119:0] iresp_cidcsd,
  output logic         oresp_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_WAIT = 2'd2,
    ST_TX   = 2'd3
  } state_e;

  localparam logic [15:0] NCR_M1 = 16'(NCR - 1);
  localparam logic [15:0] TMO_M1 = 16'(RESP_TIMEOUT - 1);

  // Serial CRC7 step, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_e         state_q, state_d;
  logic [5:0]     rxcnt_q, rxcnt_d;
  logic [45:0]    rxsh_q, rxsh_d;     // frame bits 46..1 once the end bit arrives
  logic [6:0]     crc_q, crc_d;       // shared by receive check and transmit generation
  logic [15:0]    cyc_q, cyc_d;       // cycles since the end-bit edge
  logic [127:0]   txsh_q, txsh_d;     // response bits ahead of the CRC field, MSB first
  logic           long_q, long_d;
  logic [7:0]     txpos_q, txpos_d;   // index of the next response bit to drive
  logic           sd_q, sd_d;
  logic           en_q, en_d;
  logic           valid_q, valid_d;
  logic [5:0]     index_q, index_d;
  logic [31:0]    arg_q, arg_d;
  logic           crcerr_q, crcerr_d;
  logic           frameerr_q, frameerr_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;

  logic           frame_bad_s;
  logic           crc_bad_s;
  logic [15:0]    cyc_inc_s;
  logic [7:0]     n_bits_s;
  logic [7:0]     crc_pos_s;
  logic [7:0]     cov_lo_s;

  // Transmission bit is rxsh_q[45]; the end bit is still on the line.
  assign frame_bad_s = !rxsh_q[45] || !icmd_sd;

`ifdef SD_CMD_CRC_CHECK_EN
  assign crc_bad_s = (crc_q != rxsh_q[6:0]);
`else
  logic unused_rx_crc_s;
  assign unused_rx_crc_s = ^rxsh_q[6:0];
  assign crc_bad_s = 1'b0;
`endif

  assign cyc_inc_s = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
  assign n_bits_s  = long_q ? 8'd136 : 8'd48;
  assign crc_pos_s = long_q ? 8'd128 : 8'd40;
  // R2 CRC excludes start, transmission and the reserved 6'b111111 field.
  assign cov_lo_s  = long_q ? 8'd8 : 8'd0;

  // State and output registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= ST_IDLE;
      rxcnt_q    <= 6'd0;
      rxsh_q     <= 46'd0;
      crc_q      <= 7'd0;
      cyc_q      <= 16'd0;
      txsh_q     <= 128'd0;
      long_q     <= 1'b0;
      txpos_q    <= 8'd0;
      sd_q       <= 1'b1;
      en_q       <= 1'b0;
      valid_q    <= 1'b0;
      index_q    <= 6'd0;
      arg_q      <= 32'd0;
      crcerr_q   <= 1'b0;
      frameerr_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxcnt_q    <= rxcnt_d;
      rxsh_q     <= rxsh_d;
      crc_q      <= crc_d;
      cyc_q      <= cyc_d;
      txsh_q     <= txsh_d;
      long_q     <= long_d;
      txpos_q    <= txpos_d;
      sd_q       <= sd_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
      crcerr_q   <= crcerr_d;
      frameerr_q <= frameerr_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    rxcnt_d    = rxcnt_q;
    rxsh_d     = rxsh_q;
    crc_d      = crc_q;
    cyc_d      = cyc_q;
    txsh_d     = txsh_q;
    long_d     = long_q;
    txpos_d    = txpos_q;
    sd_d       = 1'b1;
    en_d       = 1'b0;
    valid_d    = 1'b0;
    index_d    = index_q;
    arg_d      = arg_q;
    crcerr_d   = 1'b0;
    frameerr_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!icmd_sd) begin
          state_d = ST_RX;
          rxcnt_d = 6'd1;
          rxsh_d  = 46'd0;
          crc_d   = 7'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RX: begin
        if (rxcnt_q == 6'd47) begin
          // End-bit edge: framing faults take priority over CRC faults.
          if (frame_bad_s) begin
            frameerr_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (crc_bad_s) begin
            crcerr_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            valid_d = 1'b1;
            index_d = rxsh_q[44:39];
            arg_d   = rxsh_q[38:7];
            cyc_d   = 16'd0;
            state_d = ST_WAIT;
          end
        end else begin
          rxsh_d  = {rxsh_q[44:0], icmd_sd};
          rxcnt_d = rxcnt_q + 6'd1;
          // Bits 46..8 feed the CRC; bits 7..1 are the received CRC.
          if (rxcnt_q <= 6'd39) begin
            crc_d = crc7_step(crc_q, icmd_sd);
          end else begin
            crc_d = crc_q;
          end
        end
      end

      ST_WAIT: begin
        if (iresp_valid) begin
          state_d = ST_TX;
          long_d  = iresp_long;
          crc_d   = 7'd0;
          txpos_d = 8'd0;
          cyc_d   = cyc_inc_s;
          if (iresp_long) begin
            txsh_d = {2'b00, 6'h3F, iresp_cidcsd};
          end else begin
            txsh_d = {2'b00, iresp_index, iresp_arg, 88'd0};
          end
        end else if (!icmd_sd) begin
          // Unanswered command followed by a new one.
          state_d = ST_RX;
          rxcnt_d = 6'd1;
          rxsh_d  = 46'd0;
          crc_d   = 7'd0;
        end else if (cyc_q == TMO_M1) begin
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_inc_s;
        end
      end

      ST_TX: begin
        if (!en_q && (cyc_q < NCR_M1)) begin
          // Hold the line released until NCR cycles after the end bit.
          cyc_d = cyc_inc_s;
        end else if (txpos_q == n_bits_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          en_d    = 1'b1;
          txpos_d = txpos_q + 8'd1;
          if (txpos_q < crc_pos_s) begin
            sd_d   = txsh_q[127];
            txsh_d = {txsh_q[126:0], 1'b0};
            if (txpos_q >= cov_lo_s) begin
              crc_d = crc7_step(crc_q, txsh_q[127]);
            end else begin
              crc_d = crc_q;
            end
          end else if (txpos_q < (n_bits_s - 8'd1)) begin
            sd_d  = crc_q[6];
            crc_d = {crc_q[5:0], 1'b0};
          end else begin
            sd_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_WAIT);
  end

  assign ocmd_sd     = sd_q;
  assign ocmd_sd_en  = en_q;
  assign ocmd_valid  = valid_q;
  assign ocmd_index  = index_q;
  assign ocmd_arg    = arg_q;
  assign ocrc_err    = crcerr_q;
  assign oframe_err  = frameerr_q;
  assign oresp_ready = ready_q;
  assign oresp_done  = done_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
module tb_sd_cmd_responder;
  localparam int NCR = 2;
  localparam int TMO = 64;

  logic         iclk = 1'b0;
  logic         irst_n;
  logic         icmd_sd;
  logic         ocmd_sd;
  logic         ocmd_sd_en;
  logic         ocmd_valid;
  logic [5:0]   ocmd_index;
  logic [31:0]  ocmd_arg;
  logic         ocrc_err;
  logic         oframe_err;
  logic         oresp_ready;
  logic         iresp_valid;
  logic         iresp_long;
  logic [5:0]   iresp_index;
  logic [31:0]  iresp_arg;
  logic [119:0] iresp_cidcsd;
  logic         oresp_done;

  sd_cmd_responder #(.NCR(NCR), .RESP_TIMEOUT(TMO)) dut (
    .iclk(iclk), .irst_n(irst_n), .icmd_sd(icmd_sd),
    .ocmd_sd(ocmd_sd), .ocmd_sd_en(ocmd_sd_en),
    .ocmd_valid(ocmd_valid), .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg),
    .ocrc_err(ocrc_err), .oframe_err(oframe_err), .oresp_ready(oresp_ready),
    .iresp_valid(iresp_valid), .iresp_long(iresp_long),
    .iresp_index(iresp_index), .iresp_arg(iresp_arg),
    .iresp_cidcsd(iresp_cidcsd), .oresp_done(oresp_done)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  kind;   // {valid, crc_err, frame_err}
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_exp_t;

  typedef struct {
    logic [135:0] frame;
    int           nbits;
    int           start;
  } resp_exp_t;

  cmd_exp_t  exp_cmd[$];
  resp_exp_t exp_resp[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference CRC7 by augmented polynomial long division.
  function automatic logic [6:0] ref_crc7(input logic [119:0] msg);
    logic [7:0] rem;
    rem = 8'h00;
    for (int i = 119; i >= 0; i--) begin
      rem = {rem[6:0], msg[i]};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    for (int i = 0; i < 7; i++) begin
      rem = {rem[6:0], 1'b0};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic [135:0] got;
  int           got_n;
  int           got_start;
  bit           collecting = 1'b0;
  always @(negedge iclk) begin
    cmd_exp_t  ce;
    resp_exp_t re;
    if (!irst_n) begin
      if (collecting) begin
        if (exp_resp.size() > 0) void'(exp_resp.pop_front());
        collecting = 1'b0;
      end
    end else begin
      if (ocmd_valid || ocrc_err || oframe_err) begin
        if (exp_cmd.size() == 0) begin
          check("unexpected_cmd_event", {ocmd_valid, ocrc_err, oframe_err}, 3'b000);
        end else begin
          ce = exp_cmd.pop_front();
          check("cmd_kind", {ocmd_valid, ocrc_err, oframe_err}, ce.kind);
          if (ce.kind == 3'b100) begin
            check("cmd_index", ocmd_index, ce.idx);
            check("cmd_arg", ocmd_arg, ce.arg);
          end
        end
      end
      if (ocmd_sd_en) begin
        if (!collecting) begin
          collecting = 1'b1;
          got        = 136'd0;
          got_n      = 0;
          got_start  = cyc;
        end
        got = {got[134:0], ocmd_sd};
        got_n++;
      end else if (collecting) begin
        collecting = 1'b0;
        if (exp_resp.size() == 0) begin
          check("unexpected_response", 1'b1, 1'b0);
        end else begin
          re = exp_resp.pop_front();
          check("resp_len", got_n, re.nbits);
          check("resp_bits", got, re.frame);
          check("resp_start_cycle", got_start, re.start);
          check("resp_done_pulse", oresp_done, 1'b1);
          check("resp_line_idle", ocmd_sd, 1'b1);
        end
      end else if (oresp_done) begin
        check("unexpected_done", 1'b1, 1'b0);
      end
    end
  end

  task automatic push_cmd(input logic [2:0] kind, input logic [5:0] idx, input logic [31:0] arg);
    cmd_exp_t c;
    c.kind = kind; c.idx = idx; c.arg = arg;
    exp_cmd.push_back(c);
  endtask

  // Drive a 48-bit token; returns E (edge that samples the end bit).
  task automatic send_cmd(input logic [47:0] f, input bit now, output int e);
    for (int i = 47; i >= 0; i--) begin
      if (!(now && i == 47)) @(negedge iclk);
      icmd_sd = f[i];
    end
    @(negedge iclk);
    icmd_sd = 1'b1;
    e = cyc;
  endtask

  // Issue a request at the current negedge (accepted at the next edge).
  task automatic request(input bit lng, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [119:0] cid, input logic [135:0] frame, input int e);
    resp_exp_t r;
    int a;
    a = cyc + 1;
    r.frame = frame;
    r.nbits = lng ? 136 : 48;
    r.start = (e + NCR > a + 1) ? e + NCR : a + 1;
    exp_resp.push_back(r);
    iresp_valid = 1'b1; iresp_long = lng; iresp_index = idx; iresp_arg = arg; iresp_cidcsd = cid;
    @(negedge iclk);
    iresp_valid = 1'b0; iresp_long = ~lng; iresp_index = 6'h2A; iresp_arg = 32'h5555AAAA;
    iresp_cidcsd = ~cid;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge iclk);
      if (oresp_done) begin ok = 1'b1; break; end
    end
    check("done_wait_bound", ok, 1'b1);
  endtask

  localparam logic [47:0]  CMD8     = 48'h48000001AA87;
  localparam logic [47:0]  CMD8_BAD = 48'h48000001AA89;
  localparam logic [47:0]  CMD0     = 48'h400000000095;
  localparam logic [47:0]  CMD55    = 48'h770000000065;
  localparam logic [47:0]  R7_8     = 48'h08000001AA13;
  localparam logic [119:0] CSD      = 120'h400E00325B5900003B377F800A4000;

  initial begin
    int e;
    bit seen;
    irst_n = 1'b0; icmd_sd = 1'b1; iresp_valid = 1'b0; iresp_long = 1'b0;
    iresp_index = 6'd0; iresp_arg = 32'd0; iresp_cidcsd = 120'd0;
    repeat (3) @(negedge iclk);
    check("rst_sd", ocmd_sd, 1'b1);
    check("rst_en", ocmd_sd_en, 1'b0);
    check("rst_pulses", {ocmd_valid, ocrc_err, oframe_err, oresp_done}, 4'b0000);
    check("rst_fields", {ocmd_index, ocmd_arg}, 38'd0);
    check("rst_ready", oresp_ready, 1'b0);
    irst_n = 1'b1;
    repeat (2) @(negedge iclk);

    // CMD8 with R7 response at E+NCR, next command right after done.
    push_cmd(3'b100, 6'd8, 32'h000001AA);
    send_cmd(CMD8, 1'b0, e);
    check("cmd8_ready", oresp_ready, 1'b1);
    request(1'b0, 6'd8, 32'h000001AA, 120'd0, {88'd0, R7_8}, e);
    wait_done();

    // CMD0 unanswered, CMD55 eight cycles later, then timeout.
    push_cmd(3'b100, 6'd0, 32'd0);
    send_cmd(CMD0, 1'b1, e);
    repeat (8) @(negedge iclk);
    push_cmd(3'b100, 6'd55, 32'd0);
    send_cmd(CMD55, 1'b0, e);
    repeat (TMO - 1) @(negedge iclk);
    check("ready_before_timeout", oresp_ready, 1'b1);
    @(negedge iclk);
    check("ready_after_timeout", oresp_ready, 1'b0);
    repeat (2) @(negedge iclk);

    // Corrupted CRC.
`ifdef SD_CMD_CRC_CHECK_EN
    push_cmd(3'b010, 6'd0, 32'd0);
    send_cmd(CMD8_BAD, 1'b0, e);
    check("crcerr_no_wait", oresp_ready, 1'b0);
`else
    push_cmd(3'b100, 6'd8, 32'h000001AA);
    send_cmd(CMD8_BAD, 1'b0, e);
    check("nocrc_wait", oresp_ready, 1'b1);
`endif
    repeat (3) @(negedge iclk);

    // Transmission bit 0.
    push_cmd(3'b001, 6'd0, 32'd0);
    send_cmd(R7_8, 1'b0, e);
    check("frameerr_no_wait", oresp_ready, 1'b0);
    repeat (3) @(negedge iclk);

    // R2 accepted late: start follows acceptance by one cycle.
    push_cmd(3'b100, 6'd8, 32'h000001AA);
    send_cmd(CMD8, 1'b0, e);
    repeat (5) @(negedge iclk);
    request(1'b1, 6'd0, 32'd0, CSD, {8'h3F, CSD, ref_crc7(CSD), 1'b1}, e);
    wait_done();
    repeat (3) @(negedge iclk);

    // Reset in the middle of a response.
    push_cmd(3'b100, 6'd8, 32'h000001AA);
    send_cmd(CMD8, 1'b0, e);
    request(1'b0, 6'd8, 32'h000001AA, 120'd0, {88'd0, R7_8}, e);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ocmd_sd_en) begin seen = 1'b1; break; end
      @(negedge iclk);
    end
    check("tx_started", seen, 1'b1);
    repeat (20) @(negedge iclk);
    #2 irst_n = 1'b0;
    #1;
    check("rst_mid_tx_en", ocmd_sd_en, 1'b0);
    check("rst_mid_tx_sd", ocmd_sd, 1'b1);
    repeat (3) @(negedge iclk);
    irst_n = 1'b1;
    repeat (2) @(negedge iclk);
    check("post_rst_ready", oresp_ready, 1'b0);

    push_cmd(3'b100, 6'd8, 32'h000001AA);
    send_cmd(CMD8, 1'b0, e);
    request(1'b0, 6'd8, 32'h000001AA, 120'd0, {88'd0, R7_8}, e);
    wait_done();
    repeat (5) @(negedge iclk);

    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("resp_queue_drained", exp_resp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
